adc_dac_loop_spec: RTL and testbench

ADC_DAC_LOOP_SPEC -- requirements
Module: adc_dac_loop

---
 rtl/adc_dac_loop_spec.sv | 108 ++++++++++
 tb/tb_adc_dac_loop_spec.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_dac_loop_spec.sv
// adc_dac_loop_spec: 1024-sample averaging loop from ADC samples to two DAC code outputs.
// Define ADC_DAC_LOOP_GPOUT_STATUS_EN to drive the GP_OUT status word (otherwise GP_OUT is 0).
module adc_dac_loop_spec #(
  parameter int unsigned FLOAT_WIDTH = 64,
  parameter int unsigned ADC_WIDTH   = 12,
  parameter int unsigned DAC_WIDTH   = 14,
  parameter int unsigned GPIO_WIDTH  = 32
) (
  input  logic                  ADC_CLK,
  input  logic                  RST,
  input  logic [ADC_WIDTH-1:0]  ADC_DATA_IN,
  input  logic [GPIO_WIDTH-1:0] GP_IN,
  output logic [GPIO_WIDTH-1:0] GP_OUT,
  output logic                  DONE,
  output logic [DAC_WIDTH-1:0]  DACA_CODE_OUT,
  output logic [DAC_WIDTH-1:0]  DACB_CODE_OUT
);

  localparam int unsigned CNT_WIDTH = 10;
  localparam int unsigned SHIFT     = DAC_WIDTH - ADC_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = '1;

  logic enable_c;
  logic clear_c;
  logic unused_gp_in;

  assign enable_c     = GP_IN[0];
  assign clear_c      = GP_IN[1];
  assign unused_gp_in = ^GP_IN[GPIO_WIDTH-1:2];

  logic [FLOAT_WIDTH-1:0] acc, acc_d, sum_c;
  logic [CNT_WIDTH-1:0]   cnt, cnt_d;
  logic [ADC_WIDTH-1:0]   avg_c;
  logic                   done_d;
  logic                   window_end_c;
  logic [DAC_WIDTH-1:0]   daca_d, dacb_d;

  // Accumulator is wide enough for 1024 full-scale samples, so the sum never wraps.
  assign sum_c        = acc + FLOAT_WIDTH'(ADC_DATA_IN);
  assign avg_c        = ADC_WIDTH'(sum_c >> CNT_WIDTH);
  assign window_end_c = enable_c && !clear_c && (cnt == CNT_LAST);

  // Next-state: clear/disable dominate, then window completion, then accumulation.
  always_comb begin
    acc_d  = acc;
    cnt_d  = cnt;
    done_d = 1'b0;
    daca_d = DACA_CODE_OUT;
    dacb_d = DACB_CODE_OUT;
    if (!enable_c || clear_c) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (window_end_c) begin
      acc_d  = '0;
      cnt_d  = '0;
      done_d = 1'b1;
      daca_d = DAC_WIDTH'(avg_c) << SHIFT;
    end else begin
      acc_d = sum_c;
      cnt_d = cnt + CNT_WIDTH'(1);
    end
    if (enable_c) begin
      dacb_d = DAC_WIDTH'(ADC_DATA_IN) << SHIFT;
    end
  end

  always_ff @(posedge ADC_CLK or negedge RST) begin
    if (!RST) begin
      acc           <= '0;
      cnt           <= '0;
      DONE          <= 1'b0;
      DACA_CODE_OUT <= '0;
      DACB_CODE_OUT <= '0;
    end else begin
      acc           <= acc_d;
      cnt           <= cnt_d;
      DONE          <= done_d;
      DACA_CODE_OUT <= daca_d;
      DACB_CODE_OUT <= dacb_d;
    end
  end

`ifdef ADC_DAC_LOOP_GPOUT_STATUS_EN
  logic        valid;
  logic        enable_q;
  logic [15:0] win_count;

  // Status: sticky VALID, registered ENABLE echo and a wrapping completion counter.
  always_ff @(posedge ADC_CLK or negedge RST) begin
    if (!RST) begin
      valid     <= 1'b0;
      enable_q  <= 1'b0;
      win_count <= '0;
    end else begin
      enable_q <= enable_c;
      if (window_end_c) begin
        valid     <= 1'b1;
        win_count <= win_count + 16'd1;
      end
    end
  end

  assign GP_OUT = GPIO_WIDTH'({win_count, 4'b0000, enable_q, valid, cnt});
`else
  assign GP_OUT = '0;
`endif

endmodule

// File: tb/tb_adc_dac_loop_spec.sv
// tb_adc_dac_loop_spec: randomized bench with window-average reference model and DONE scoreboard.
// Honours ADC_DAC_LOOP_GPOUT_STATUS_EN the same way as the design.
module tb_adc_dac_loop_spec;
  localparam int unsigned FW = 64;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 14;
  localparam int unsigned GW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] adc;
  logic [GW-1:0] gp_in;
  logic [GW-1:0] gp_out;
  logic          done;
  logic [DW-1:0] daca;
  logic [DW-1:0] dacb;

  always #5 clk = ~clk;

  adc_dac_loop_spec #(
    .FLOAT_WIDTH(FW), .ADC_WIDTH(AW), .DAC_WIDTH(DW), .GPIO_WIDTH(GW)
  ) dut (
    .ADC_CLK(clk), .RST(rst_n), .ADC_DATA_IN(adc), .GP_IN(gp_in),
    .GP_OUT(gp_out), .DONE(done), .DACA_CODE_OUT(daca), .DACB_CODE_OUT(dacb)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: window contents as a running sum and length.
  logic [DW-1:0] exp_q[$];
  longint        win_sum;
  int            win_len;
  logic [DW-1:0] m_daca, m_dacb;
  logic          m_valid, m_en;
  int            m_cmpl;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [DW-1:0] scale(input longint v);
    return DW'(v * (longint'(1) << (DW - AW)));
  endfunction

  function automatic logic [GW-1:0] exp_gp();
`ifdef ADC_DAC_LOOP_GPOUT_STATUS_EN
    return {16'(m_cmpl), 4'b0000, m_en, m_valid, 10'(win_len)};
`else
    return '0;
`endif
  endfunction

  task automatic model_reset();
    win_sum = 0; win_len = 0; m_daca = '0; m_dacb = '0;
    m_valid = 1'b0; m_en = 1'b0; m_cmpl = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic en, input logic clr, input logic [AW-1:0] d);
    m_en = en;
    if (en) m_dacb = scale(longint'(d));
    if (!en || clr) begin
      win_sum = 0; win_len = 0;
    end else begin
      win_sum += longint'(d);
      win_len++;
      if (win_len == 1024) begin
        m_daca = scale(win_sum / 1024);
        exp_q.push_back(m_daca);
        m_valid = 1'b1;
        m_cmpl  = (m_cmpl + 1) % 65536;
        win_sum = 0; win_len = 0;
      end
    end
  endtask

  task automatic check_state();
    chk("daca", 64'(daca), 64'(m_daca));
    chk("dacb", 64'(dacb), 64'(m_dacb));
    chk("gp_out", 64'(gp_out), 64'(exp_gp()));
  endtask

  // On return the DUT reflects every earlier step; this step's edge is still pending.
  task automatic step(input logic en, input logic clr, input logic [AW-1:0] d);
    @(negedge clk);
    check_state();
    gp_in = {30'($urandom), clr, en};
    adc   = d;
    model_edge(en, clr, d);
  endtask

  task automatic hold();
    step(1'b0, 1'b0, AW'($urandom));
  endtask

  // Scoreboard monitor: every DONE pulse must match one queued window result.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL done_unexpected: got DONE=1, expected DONE=0 (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("done_daca", 64'(daca), 64'(e));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] prev;
    gp_in = '0; adc = '0;
    model_reset();
    #12;
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_daca", 64'(daca), 64'd0);
    chk("rst_dacb", 64'(dacb), 64'd0);
    chk("rst_gp_out", 64'(gp_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_edge(1'b0, 1'b0, '0);

    // Constant 0x005 window.
    hold();
    repeat (1024) step(1'b1, 1'b0, 12'h005);
    hold();
    chk("c5_done", 64'(done), 64'd1);
    chk("c5_daca", 64'(daca), 64'h0014);
`ifdef ADC_DAC_LOOP_GPOUT_STATUS_EN
    chk("c5_count", 64'(gp_out[31:16]), 64'd1);
    chk("c5_valid", 64'(gp_out[10]), 64'd1);
`endif

    // Ramp: one value per window.
    for (int w = 0; w < 4; w++) begin
      repeat (1024) step(1'b1, 1'b0, AW'(w));
      hold();
      chk("ramp_daca", 64'(daca), 64'(4 * w));
    end

    // Full-scale window must not wrap.
    repeat (1024) step(1'b1, 1'b0, 12'hFFF);
    hold();
    chk("fs_daca", 64'(daca), 64'h3FFC);

    // Random data window, then random data with rare disables and clears.
    repeat (1024) step(1'b1, 1'b0, AW'($urandom));
    hold();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 1999) != 0), ($urandom_range(0, 2999) == 0), AW'($urandom));
    end

    // Disable at CNT=500 discards the partial window.
    hold();
    repeat (1024) step(1'b1, 1'b0, 12'hFFF);
    hold();
    repeat (500) step(1'b1, 1'b0, AW'($urandom));
    hold();
`ifdef ADC_DAC_LOOP_GPOUT_STATUS_EN
    chk("dis_cnt", 64'(gp_out[9:0]), 64'd500);
`endif
    hold(); hold();
    repeat (1024) step(1'b1, 1'b0, 12'h000);
    chk("dis_no_done", 64'(done), 64'd0);
    chk("dis_daca_hold", 64'(daca), 64'h3FFC);
    hold();
    chk("dis_done", 64'(done), 64'd1);
    chk("dis_daca", 64'(daca), 64'h0000);

    // CLEAR on the final sample of a window suppresses completion.
    prev = m_daca;
    repeat (1023) step(1'b1, 1'b0, AW'($urandom));
    step(1'b1, 1'b1, AW'($urandom));
    hold();
    chk("clr_no_done", 64'(done), 64'd0);
    chk("clr_daca", 64'(daca), 64'(prev));
`ifdef ADC_DAC_LOOP_GPOUT_STATUS_EN
    chk("clr_cnt", 64'(gp_out[9:0]), 64'd0);
`endif

    // Asynchronous reset mid-window.
    repeat (300) step(1'b1, 1'b0, AW'($urandom));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_daca", 64'(daca), 64'd0);
    chk("arst_dacb", 64'(dacb), 64'd0);
    chk("arst_gp_out", 64'(gp_out), 64'd0);
    model_reset();
    @(negedge clk);
    gp_in = '0;
    rst_n = 1'b1;
    model_edge(1'b0, 1'b0, '0);

    // Fresh window after reset release.
    repeat (1024) step(1'b1, 1'b0, AW'($urandom));
    hold();
    chk("post_rst_done", 64'(done), 64'd1);
    hold(); hold();
    chk("pending", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
